treasure_color_detect: RTL and testbench
========================================

// Module: treasure_color_detect
// PURPOSE
//  Consumes the RGB332 pixel stream from the camera capture stage (PIXEL_COLOR, W_EN, X, Y).
//  Counts red and blue pixels inside a rectangular window once per frame.
//  Classifies the frame as NONE, RED or BLUE at each frame boundary (VSYNC rising edge).
//  The result feeds the Arduino-facing output pins.
// PARAMETERS
//  X_MIN     10'd40   first window column (inclusive)
//  X_MAX     10'd136  last window column (exclusive)
//  Y_MIN     10'd20   first window row (inclusive)
//  Y_MAX     10'd124  last window row (exclusive)
//  CNT_W     14       width of the pixel counters
//  THRESH    14'd100  minimum count needed to declare a colour
//  DEB_FRAMES 3       consecutive agreeing frames required (DEBOUNCE_EN only), range 1..7
// PORTS
//  PCLK         in   1      pixel clock, same clock as the capture stage
//  RESET        in   1      asynchronous, active-high
//  VSYNC        in   1      camera VSYNC, level
//  W_EN         in   1      pixel-valid strobe from capture
//  X            in   10     pixel column
//  Y            in   10     pixel row
//  PIXEL_COLOR  in   8      RGB332 pixel: R=[7:5], G=[4:2], B=[1:0]
//  RESULT       out  2      2'b00 NONE, 2'b01 RED, 2'b10 BLUE (2'b11 never driven)
//  RESULT_VALID out  1      one-cycle pulse per completed frame
//  RED_COUNT    out  CNT_W  red count of the last completed frame
//  BLUE_COUNT   out  CNT_W  blue count of the last completed frame
// BEHAVIOUR
//  - Reset (async): all outputs 0; accumulators 0; state IDLE; stored VSYNC value 0.
//  - VSYNC edge: a rising edge is VSYNC=1 with the stored previous VSYNC=0. The stored value updates every cycle.
//  - In window: X_MIN<=X<X_MAX and Y_MIN<=Y<Y_MAX. Unsigned 10-bit compares.
//  - Classification, only when W_EN=1 and the pixel is in the window:
//      red:  R>=5 and G<=2 and B<=1
//      blue: B>=2 and R<=2 and G<=3
//      red and blue are mutually exclusive by construction.
//  - Accumulators saturate at 2^CNT_W-1 and never wrap.
//  - FSM states: IDLE, ACCUM, DECIDE.
//      IDLE: accumulators held at 0. On a VSYNC edge go to ACCUM. No result for this partial frame.
//      ACCUM: count pixels. On a VSYNC edge:
//        - copy the accumulators into RED_COUNT and BLUE_COUNT;
//        - clear the accumulators;
//        - go to DECIDE.
//        A pixel strobe in that same cycle is discarded.
//      DECIDE (1 cycle): drive RESULT from RED_COUNT/BLUE_COUNT, pulse RESULT_VALID=1, go to ACCUM.
//        Pixels in this cycle count toward the new frame.
//  - Decision rule:
//      RED  if red>=THRESH and red>blue;
//      BLUE if blue>=THRESH and blue>red;
//      else NONE (ties are NONE).
//  - Latency: RESULT/RESULT_VALID change 2 PCLK edges after the edge that samples VSYNC rising.
//  - RESULT holds its value between pulses. RESULT_VALID is 0 except in the DECIDE cycle.
//  - Reset mid-frame returns to IDLE. The first frame after reset never produces a pulse.
//  - A VSYNC edge while in DECIDE cannot occur (VSYNC high lasts many lines). No special handling.
// CONFIGURATION
//  DEBOUNCE_EN defined:
//    - RESULT changes only after DEB_FRAMES consecutive frames decide the same new class.
//    - A 3-bit agree counter resets whenever the decision differs from the candidate class.
//    - RESULT_VALID still pulses every frame. RED_COUNT/BLUE_COUNT are unaffected.
//  DEBOUNCE_EN undefined: RESULT takes each frame's decision directly. No agree counter is built.
// TESTING
//  1. Reset, then 2 frames, each with 8'hE0 on every in-window pixel ->
//     no pulse after frame 1; after frame 2 RED_COUNT=9984, BLUE_COUNT=0, RESULT=01 with one pulse.
//  2. Frame with 8'h03 in 500 in-window pixels and 8'hFF elsewhere -> BLUE_COUNT=500, RESULT=10.
//  3. 99 red pixels in window (below THRESH) -> RESULT=00; 100 red pixels -> RESULT=01.
//  4. 600 red plus 600 blue in window, and 5000 red at X=10 (outside window) -> RED_COUNT=600, RESULT=00.
//  5. Assert RESET mid-frame with 300 red counted ->
//     outputs 0 immediately; next VSYNC edge gives no pulse; the following frame reports a fresh count.
//  6. With DEBOUNCE_EN, DEB_FRAMES=3, frames decided RED,RED,BLUE,RED,RED,RED ->
//     RESULT stays 00 through frame 5, becomes 01 at frame 6; 6 pulses total.

Source files
------------

// File: rtl/treasure_color_detect.sv
// Counts red/blue RGB332 pixels inside a fixed window and classifies each frame at VSYNC.
// Optional `DEBOUNCE_EN: RESULT only changes after DEB_FRAMES consecutive agreeing frames.
module treasure_color_detect #(
    parameter logic [9:0] X_MIN      = 10'd40,
    parameter logic [9:0] X_MAX      = 10'd136,
    parameter logic [9:0] Y_MIN      = 10'd20,
    parameter logic [9:0] Y_MAX      = 10'd124,
    parameter int         CNT_W      = 14,
    parameter int         THRESH     = 100,
    parameter int         DEB_FRAMES = 3
) (
    input  logic             PCLK,
    input  logic             RESET,
    input  logic             VSYNC,
    input  logic             W_EN,
    input  logic [9:0]       X,
    input  logic [9:0]       Y,
    input  logic [7:0]       PIXEL_COLOR,
    output logic [1:0]       RESULT,
    output logic             RESULT_VALID,
    output logic [CNT_W-1:0] RED_COUNT,
    output logic [CNT_W-1:0] BLUE_COUNT
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DECIDE} state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_RED  = 2'b01;
    localparam logic [1:0] CLS_BLUE = 2'b10;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic [CNT_W-1:0] red_acc_q, red_acc_d, blue_acc_q, blue_acc_d;
    logic [CNT_W-1:0] red_count_q, red_count_d, blue_count_q, blue_count_d;
    logic [1:0]       result_q, result_d;
    logic             valid_q, valid_d;

    logic             vsync_edge, in_win, px_red, px_blue;
    logic [2:0]       r_val, g_val;
    logic [1:0]       b_val;
    logic [1:0]       decision, deb_result;

    always_comb begin
        vsync_edge = VSYNC & ~vsync_q;
        in_win     = (X >= X_MIN) && (X < X_MAX) && (Y >= Y_MIN) && (Y < Y_MAX);
        r_val      = PIXEL_COLOR[7:5];
        g_val      = PIXEL_COLOR[4:2];
        b_val      = PIXEL_COLOR[1:0];
        px_red     = W_EN && in_win && (r_val >= 3'd5) && (g_val <= 3'd2) && (b_val <= 2'd1);
        px_blue    = W_EN && in_win && (b_val >= 2'd2) && (r_val <= 3'd2) && (g_val <= 3'd3);
    end

    // Ties and sub-threshold counts both fall through to NONE.
    always_comb begin
        decision = CLS_NONE;
        if (red_count_q >= THRESH_C && red_count_q > blue_count_q) begin
            decision = CLS_RED;
        end else if (blue_count_q >= THRESH_C && blue_count_q > red_count_q) begin
            decision = CLS_BLUE;
        end
    end

`ifdef DEBOUNCE_EN
    logic [1:0] cand_q, cand_d;
    logic [2:0] agree_q, agree_d;

    always_comb begin
        cand_d     = cand_q;
        agree_d    = agree_q;
        deb_result = result_q;
        if (state_q == S_DECIDE) begin
            if (decision != cand_q) begin
                cand_d  = decision;
                agree_d = 3'd1;
            end else if (agree_q != 3'd7) begin
                agree_d = agree_q + 3'd1;
            end
            if (agree_d >= 3'(DEB_FRAMES)) begin
                deb_result = cand_d;
            end
        end
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            cand_q  <= CLS_NONE;
            agree_q <= 3'd0;
        end else begin
            cand_q  <= cand_d;
            agree_q <= agree_d;
        end
    end
`else
    assign deb_result = decision;
`endif

    always_comb begin
        state_d      = state_q;
        red_acc_d    = red_acc_q;
        blue_acc_d   = blue_acc_q;
        red_count_d  = red_count_q;
        blue_count_d = blue_count_q;
        result_d     = result_q;
        valid_d      = 1'b0;
        // Counters saturate at all-ones rather than wrapping.
        if (px_red && red_acc_q != '1) begin
            red_acc_d = red_acc_q + CNT_W'(1);
        end
        if (px_blue && blue_acc_q != '1) begin
            blue_acc_d = blue_acc_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                red_acc_d  = '0;
                blue_acc_d = '0;
                if (vsync_edge) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (vsync_edge) begin
                    red_count_d  = red_acc_q;
                    blue_count_d = blue_acc_q;
                    red_acc_d    = '0;
                    blue_acc_d   = '0;
                    state_d      = S_DECIDE;
                end
            end
            S_DECIDE: begin
                result_d = deb_result;
                valid_d  = 1'b1;
                state_d  = S_ACCUM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            red_acc_q    <= '0;
            blue_acc_q   <= '0;
            red_count_q  <= '0;
            blue_count_q <= '0;
            result_q     <= CLS_NONE;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= VSYNC;
            red_acc_q    <= red_acc_d;
            blue_acc_q   <= blue_acc_d;
            red_count_q  <= red_count_d;
            blue_count_q <= blue_count_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
        end
    end

    assign RESULT       = result_q;
    assign RESULT_VALID = valid_q;
    assign RED_COUNT    = red_count_q;
    assign BLUE_COUNT   = blue_count_q;

endmodule

// File: tb/tb_treasure_color_detect.sv
// Directed bench for treasure_color_detect; expected frame results are queued per VSYNC
// and checked whenever RESULT_VALID pulses.
module tb_treasure_color_detect;

    localparam int THRESH = 100;
    localparam int DEB    = 3;

    logic        PCLK = 1'b0;
    logic        RESET, VSYNC, W_EN;
    logic [9:0]  X, Y;
    logic [7:0]  PIXEL_COLOR;
    logic [1:0]  RESULT;
    logic        RESULT_VALID;
    logic [13:0] RED_COUNT, BLUE_COUNT;

    typedef struct {
        logic [1:0]  res;
        logic [13:0] red;
        logic [13:0] blue;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0;
    int pulses = 0, exp_pulses = 0;
    logic [1:0] m_result, m_cand;
    int m_agree;

    treasure_color_detect dut (
        .PCLK(PCLK), .RESET(RESET), .VSYNC(VSYNC), .W_EN(W_EN), .X(X), .Y(Y),
        .PIXEL_COLOR(PIXEL_COLOR), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID),
        .RED_COUNT(RED_COUNT), .BLUE_COUNT(BLUE_COUNT)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        exp_t e;
        if (RESULT_VALID === 1'b1) begin
            pulses++;
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_pulse observed=pulse expected=no_pulse");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 3;
                assert (RESULT === e.res) else begin
                    failures++;
                    $error("FAIL result observed=%b expected=%b", RESULT, e.res);
                end
                assert (RED_COUNT === e.red) else begin
                    failures++;
                    $error("FAIL red_count observed=%0d expected=%0d", RED_COUNT, e.red);
                end
                assert (BLUE_COUNT === e.blue) else begin
                    failures++;
                    $error("FAIL blue_count observed=%0d expected=%0d", BLUE_COUNT, e.blue);
                end
            end
        end
    end

    function automatic logic [1:0] classify(int red, int blue);
        if (red >= THRESH && red > blue) return 2'b01;
        if (blue >= THRESH && blue > red) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic send(int n, logic [9:0] x, logic [9:0] y, logic [7:0] c);
        W_EN = 1'b1; X = x; Y = y; PIXEL_COLOR = c;
        repeat (n) tick();
        W_EN = 1'b0;
    endtask

    task automatic send_window(logic [7:0] c);
        for (int yy = 20; yy < 124; yy++) begin
            for (int xx = 40; xx < 136; xx++) begin
                W_EN = 1'b1; X = 10'(xx); Y = 10'(yy); PIXEL_COLOR = c;
                tick();
            end
        end
        W_EN = 1'b0;
    endtask

    // edge_px: red pixel in the edge cycle (must be dropped);
    // decide_px: red pixel one cycle later (belongs to the next frame).
    task automatic vsync(bit edge_px, bit decide_px, bit expect_pulse, int red, int blue);
        exp_t e;
        logic [1:0] dec;
        if (expect_pulse) begin
            dec = classify(red, blue);
`ifdef DEBOUNCE_EN
            if (dec != m_cand) begin
                m_cand  = dec;
                m_agree = 1;
            end else if (m_agree < 7) begin
                m_agree++;
            end
            if (m_agree >= DEB) m_result = m_cand;
`else
            m_result = dec;
`endif
            e.res  = m_result;
            e.red  = 14'(red);
            e.blue = 14'(blue);
            sb.push_back(e);
            exp_pulses++;
        end
        VSYNC = 1'b1; W_EN = edge_px; X = 10'd50; Y = 10'd50; PIXEL_COLOR = 8'hE0;
        tick();
        W_EN = decide_px;
        tick();
        W_EN = 1'b0;
        repeat (3) tick();
        VSYNC = 1'b0;
        repeat (4) tick();
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL pulse_missing observed=%0d_pending expected=0_pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs();
        checks += 4;
        assert (RESULT === 2'b00) else begin
            failures++; $error("FAIL rst_result observed=%b expected=00", RESULT);
        end
        assert (RESULT_VALID === 1'b0) else begin
            failures++; $error("FAIL rst_valid observed=%b expected=0", RESULT_VALID);
        end
        assert (RED_COUNT === 14'd0) else begin
            failures++; $error("FAIL rst_red observed=%0d expected=0", RED_COUNT);
        end
        assert (BLUE_COUNT === 14'd0) else begin
            failures++; $error("FAIL rst_blue observed=%0d expected=0", BLUE_COUNT);
        end
    endtask

    initial begin
        RESET = 1'b1; VSYNC = 1'b0; W_EN = 1'b0; X = '0; Y = '0; PIXEL_COLOR = '0;
        m_result = 2'b00; m_cand = 2'b00; m_agree = 0;
        #2;
        check_zero_outputs();
        repeat (2) tick();
        RESET = 1'b0;
        tick();

        // Partial first frame is ignored; the second full red window is reported
        send_window(8'hE0);
        vsync(0, 0, 0, 0, 0);
        send_window(8'hE0);
        vsync(0, 0, 1, 9984, 0);

        // Window edges: four inside, six outside
        send(1, 10'd40, 10'd50, 8'hE0);
        send(1, 10'd135, 10'd50, 8'hE0);
        send(1, 10'd50, 10'd20, 8'hE0);
        send(1, 10'd50, 10'd123, 8'hE0);
        send(1, 10'd39, 10'd50, 8'hE0);
        send(1, 10'd136, 10'd50, 8'hE0);
        send(1, 10'd50, 10'd19, 8'hE0);
        send(1, 10'd50, 10'd124, 8'hE0);
        send(1, 10'd0, 10'd0, 8'hE0);
        send(1, 10'd1023, 10'd1023, 8'hE0);
        vsync(0, 0, 1, 4, 0);

        // Blue frame with white clutter
        send(500, 10'd60, 10'd60, 8'h03);
        send(300, 10'd10, 10'd10, 8'hFF);
        send(50, 10'd60, 10'd60, 8'hFF);
        vsync(0, 0, 1, 0, 500);

        // Threshold: 99 is NONE; next frame gets 99 plus the DECIDE-cycle pixel
        send(99, 10'd70, 10'd70, 8'hE0);
        vsync(1, 1, 1, 99, 0);
        send(99, 10'd70, 10'd70, 8'hE0);
        vsync(1, 0, 1, 100, 0);

        // Tie inside window, heavy red outside
        send(600, 10'd80, 10'd80, 8'hE0);
        send(600, 10'd80, 10'd80, 8'h03);
        send(5000, 10'd10, 10'd50, 8'hE0);
        vsync(0, 0, 1, 600, 600);

        // Colour classification boundaries
        send(110, 10'd90, 10'd90, 8'hA9);
        send(120, 10'd90, 10'd90, 8'h4E);
        send(100, 10'd90, 10'd90, 8'h89);
        send(100, 10'd90, 10'd90, 8'hAD);
        send(100, 10'd90, 10'd90, 8'h6E);
        send(100, 10'd90, 10'd90, 8'h52);
        vsync(0, 0, 1, 110, 120);

        // Saturation
        send(16400, 10'd60, 10'd60, 8'hE0);
        vsync(0, 0, 1, 16383, 0);

        // Reset mid-frame
        send(300, 10'd60, 10'd60, 8'hE0);
        RESET = 1'b1;
        #1;
        check_zero_outputs();
        m_result = 2'b00; m_cand = 2'b00; m_agree = 0;
        tick();
        RESET = 1'b0;
        tick();
        vsync(0, 0, 0, 0, 0);
        send(250, 10'd60, 10'd60, 8'hE0);
        vsync(0, 0, 1, 250, 0);

        // RED, RED, BLUE, RED, RED, RED sequence
        for (int f = 0; f < 6; f++) begin
            if (f == 2) begin
                send(150, 10'd60, 10'd60, 8'h03);
                vsync(0, 0, 1, 0, 150);
            end else begin
                send(150, 10'd60, 10'd60, 8'hE0);
                vsync(0, 0, 1, 150, 0);
            end
        end

        checks++;
        assert (pulses == exp_pulses) else begin
            failures++;
            $error("FAIL pulse_count observed=%0d expected=%0d", pulses, exp_pulses);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
